// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target for the processor master port,
// with a lower-priority host preload write port and a READ_LATENCY-deep
// registered read pipeline. Out-of-range accesses set a sticky err_oor and
// never modify the array.
// Optional feature: define MEM_PARITY_EN to store an even-parity bit per word
// and expose the sticky par_err output.
module mem_responder #(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [31:0] data_in,
  input  logic        we,
  input  logic        re,
  output logic [31:0] data_out,
  output logic        rd_valid,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic        host_valid,
  output logic        host_ready,
  output logic        err_oor
`ifdef MEM_PARITY_EN
  ,
  output logic        par_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef MEM_PARITY_EN
  localparam int unsigned MW = 33;
`else
  localparam int unsigned MW = 32;
`endif

  logic [MW-1:0]           mem_q [DEPTH];

  logic [AW-1:0]           idx;
  logic [AW-1:0]           host_idx;
  logic                    addr_ok;
  logic                    host_ok;

  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [31:0]             mem_wdata;

  logic [31:0]             rd_word;

  logic [31:0]             data_pipe_q [READ_LATENCY];
  logic [31:0]             data_pipe_d [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_pipe_q;
  logic [READ_LATENCY-1:0] valid_pipe_d;

  logic                    err_oor_q;
  logic                    err_oor_d;

`ifdef MEM_PARITY_EN
  logic                    rd_par_bad;
  logic                    par_err_q;
  logic                    par_err_d;
`endif

  // Address decode, host arbitration and write-port selection.
  always_comb begin
    idx        = addr[AW-1:0];
    host_idx   = host_addr[AW-1:0];
    addr_ok    = (32'(addr) < DEPTH);
    host_ok    = (32'(host_addr) < DEPTH);
    host_ready = ~we & ~re & ~reset;
    mem_we     = 1'b0;
    mem_waddr  = idx;
    mem_wdata  = data_in;
    if (we) begin
      mem_we = addr_ok;
    end else if (host_valid && host_ready) begin
      mem_we    = host_ok;
      mem_waddr = host_idx;
      mem_wdata = host_wdata;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef MEM_PARITY_EN
      mem_q[mem_waddr] <= {^mem_wdata, mem_wdata};
`else
      mem_q[mem_waddr] <= mem_wdata;
`endif
    end
  end

  // Read word: out of range returns zero, a same-edge write is forwarded.
  always_comb begin
    rd_word = '0;
    if (addr_ok) begin
      if (we) begin
        rd_word = data_in;
      end else begin
        rd_word = mem_q[idx][31:0];
      end
    end
  end

`ifdef MEM_PARITY_EN
  // Stored-parity check on array reads (forwarded write data is not checked).
  always_comb begin
    rd_par_bad = 1'b0;
    if (addr_ok && !we) begin
      rd_par_bad = mem_q[idx][32] ^ (^mem_q[idx][31:0]);
    end
  end
`endif

  // Read pipeline next state; stages only load when a valid read arrives so
  // data_out holds its last value between reads.
  always_comb begin
    valid_pipe_d[0] = re;
    data_pipe_d[0]  = re ? rd_word : data_pipe_q[0];
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      valid_pipe_d[i] = valid_pipe_q[i-1];
      data_pipe_d[i]  = valid_pipe_q[i-1] ? data_pipe_q[i-1] : data_pipe_q[i];
    end
  end

  // Sticky error flag next state.
  always_comb begin
    err_oor_d = err_oor_q
              | ((we | re) & ~addr_ok)
              | (host_valid & host_ready & ~host_ok);
  end

`ifdef MEM_PARITY_EN
  // Sticky parity flag next state.
  always_comb begin
    par_err_d = par_err_q | (re & rd_par_bad);
  end
`endif

  // Pipeline and flag registers; reset discards all in-flight reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        data_pipe_q[i] <= '0;
      end
      valid_pipe_q <= '0;
      err_oor_q    <= 1'b0;
`ifdef MEM_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        data_pipe_q[i] <= data_pipe_d[i];
      end
      valid_pipe_q <= valid_pipe_d;
      err_oor_q    <= err_oor_d;
`ifdef MEM_PARITY_EN
      par_err_q    <= par_err_d;
`endif
    end
  end

  // Output mapping from the last pipeline stage.
  always_comb begin
    data_out = data_pipe_q[READ_LATENCY-1];
    rd_valid = valid_pipe_q[READ_LATENCY-1];
    err_oor  = err_oor_q;
`ifdef MEM_PARITY_EN
    par_err  = par_err_q;
`endif
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: two instances (READ_LATENCY 1 and 3) share the
// same stimulus; each has its own queue of expected read data, popped when
// that instance pulses rd_valid.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [31:0] data_in;
  logic        we;
  logic        re;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_valid;

  logic [31:0] data_out1, data_out3;
  logic        rd_valid1, rd_valid3;
  logic        host_ready1, host_ready3;
  logic        err_oor1, err_oor3;
`ifdef MEM_PARITY_EN
  logic        par_err1, par_err3;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] q1 [$];
  logic [31:0] q3 [$];
  logic [31:0] e1, e3;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(1024), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .we(we), .re(re),
    .data_out(data_out1), .rd_valid(rd_valid1),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_valid(host_valid),
    .host_ready(host_ready1), .err_oor(err_oor1)
`ifdef MEM_PARITY_EN
    , .par_err(par_err1)
`endif
  );

  mem_responder #(.DEPTH(1024), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .we(we), .re(re),
    .data_out(data_out3), .rd_valid(rd_valid3),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_valid(host_valid),
    .host_ready(host_ready3), .err_oor(err_oor3)
`ifdef MEM_PARITY_EN
    , .par_err(par_err3)
`endif
  );

  // Scoreboard for the latency-1 instance.
  always @(negedge clk) begin
    if (rd_valid1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rd1_unexpected: rd_valid with no pending read, data_out=%h", data_out1);
      end else begin
        e1 = q1.pop_front();
        if (data_out1 !== e1) begin
          errors++;
          $display("FAIL rd1_data: got %h expected %h", data_out1, e1);
        end
      end
    end
  end

  // Scoreboard for the latency-3 instance.
  always @(negedge clk) begin
    if (rd_valid3 === 1'b1) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL rd3_unexpected: rd_valid with no pending read, data_out=%h", data_out3);
      end else begin
        e3 = q3.pop_front();
        if (data_out3 !== e3) begin
          errors++;
          $display("FAIL rd3_data: got %h expected %h", data_out3, e3);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One processor cycle: inputs set after a falling edge, sampled at the next rising edge.
  task automatic cyc(input logic w, input logic r, input logic [15:0] a,
                     input logic [31:0] d, input logic [31:0] exp);
    @(negedge clk);
    we = w; re = r; addr = a; data_in = d; host_valid = 1'b0;
    if (r) begin
      q1.push_back(exp);
      q3.push_back(exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      we = 1'b0; re = 1'b0; host_valid = 1'b0;
    end
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    host_valid = 1'b1; host_addr = a; host_wdata = d;
  endtask

  task automatic test_reset;
    reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; data_in = '0;
    host_valid = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (host_ready1 !== 1'b0) begin
      errors++; $display("FAIL host_ready_in_reset: got %b expected 0", host_ready1);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (data_out1 !== 32'h0 || data_out3 !== 32'h0) begin
      errors++; $display("FAIL reset_data_out: got %h/%h expected 0", data_out1, data_out3);
    end
    checks++;
    if (rd_valid1 !== 1'b0 || rd_valid3 !== 1'b0) begin
      errors++; $display("FAIL reset_rd_valid: got %b/%b expected 0", rd_valid1, rd_valid3);
    end
    checks++;
    if (err_oor1 !== 1'b0 || err_oor3 !== 1'b0) begin
      errors++; $display("FAIL reset_err_oor: got %b/%b expected 0", err_oor1, err_oor3);
    end
    checks++;
    if (host_ready1 !== 1'b1 || host_ready3 !== 1'b1) begin
      errors++; $display("FAIL idle_host_ready: got %b/%b expected 1", host_ready1, host_ready3);
    end
  endtask

  task automatic test_fetch;
    host_write(16'h0000, 32'h0205_0003);
    cyc(1'b0, 1'b1, 16'h0000, 32'h0, 32'h0205_0003);
    @(negedge clk);
    re = 1'b0;
    checks++;
    if (data_out1 !== 32'h0205_0003) begin
      errors++; $display("FAIL fetch_data: got %h expected 02050003", data_out1);
    end
    checks++;
    if (rd_valid1 !== 1'b1) begin
      errors++; $display("FAIL fetch_rd_valid_high: got %b expected 1", rd_valid1);
    end
    @(negedge clk);
    checks++;
    if (rd_valid1 !== 1'b0 || data_out1 !== 32'h0205_0003) begin
      errors++; $display("FAIL fetch_hold: rd_valid=%b data_out=%h expected 0/02050003",
                         rd_valid1, data_out1);
    end
    idle(4);
  endtask

  task automatic test_store;
    cyc(1'b1, 1'b0, 16'h0010, 32'h0, 32'h0);
    #1;
    checks++;
    if (host_ready1 !== 1'b0) begin
      errors++; $display("FAIL store_host_ready: got %b expected 0", host_ready1);
    end
    cyc(1'b1, 1'b0, 16'h0010, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 16'h0010, 32'hDEAD_BEEF, 32'h0);
    cyc(1'b0, 1'b1, 16'h0010, 32'h0, 32'hDEAD_BEEF);
    idle(5);
  endtask

  task automatic test_simultaneous;
    host_write(16'h0006, 32'h0000_0066);
    @(negedge clk);
    we = 1'b1; re = 1'b1; addr = 16'h0005; data_in = 32'h0000_1234;
    host_valid = 1'b1; host_addr = 16'h0006; host_wdata = 32'hAAAA_AAAA;
    q1.push_back(32'h0000_1234);
    q3.push_back(32'h0000_1234);
    #1;
    checks++;
    if (host_ready1 !== 1'b0 || host_ready3 !== 1'b0) begin
      errors++; $display("FAIL prio_host_ready: got %b/%b expected 0", host_ready1, host_ready3);
    end
    cyc(1'b0, 1'b1, 16'h0006, 32'h0, 32'h0000_0066);
    cyc(1'b0, 1'b1, 16'h0005, 32'h0, 32'h0000_1234);
    idle(5);
  endtask

  task automatic test_out_of_range;
    cyc(1'b1, 1'b0, 16'h03FF, 32'h0BAD_F00D, 32'h0);
    cyc(1'b0, 1'b1, 16'h03FF, 32'h0, 32'h0BAD_F00D);
    idle(5);
    checks++;
    if (err_oor1 !== 1'b0) begin
      errors++; $display("FAIL boundary_no_oor: got %b expected 0", err_oor1);
    end
    cyc(1'b0, 1'b1, 16'h0400, 32'h0, 32'h0);
    idle(5);
    checks++;
    if (err_oor1 !== 1'b1 || err_oor3 !== 1'b1) begin
      errors++; $display("FAIL oor_read_flag: got %b/%b expected 1", err_oor1, err_oor3);
    end
    cyc(1'b1, 1'b0, 16'h0400, 32'hFFFF_FFFF, 32'h0);
    host_write(16'h0400, 32'hEEEE_EEEE);
    cyc(1'b0, 1'b1, 16'h0000, 32'h0, 32'h0205_0003);
    idle(8);
    checks++;
    if (err_oor1 !== 1'b1 || err_oor3 !== 1'b1) begin
      errors++; $display("FAIL oor_sticky: got %b/%b expected 1", err_oor1, err_oor3);
    end
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (err_oor1 !== 1'b0 || err_oor3 !== 1'b0) begin
      errors++; $display("FAIL oor_cleared_by_reset: got %b/%b expected 0", err_oor1, err_oor3);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      host_write(16'(16'h0020 + i), 32'hA5A5_0000 + 32'(i * 17));
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 16'(16'h0020 + i), 32'h0, 32'hA5A5_0000 + 32'(i * 17));
    end
    idle(6);
  endtask

  task automatic test_latency;
    logic exp_v [6];
    exp_v[0] = 1'b0; exp_v[1] = 1'b0; exp_v[2] = 1'b1;
    exp_v[3] = 1'b1; exp_v[4] = 1'b1; exp_v[5] = 1'b0;
    cyc(1'b0, 1'b1, 16'h0020, 32'h0, 32'hA5A5_0000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 2) begin
        addr = 16'(16'h0021 + k);
        q1.push_back(32'hA5A5_0000 + 32'((k + 1) * 17));
        q3.push_back(32'hA5A5_0000 + 32'((k + 1) * 17));
      end else begin
        re = 1'b0;
      end
      checks++;
      if (rd_valid3 !== exp_v[k]) begin
        errors++; $display("FAIL latency3_rd_valid[%0d]: got %b expected %b", k, rd_valid3, exp_v[k]);
      end
    end
    idle(3);
  endtask

  task automatic test_reset_midflight;
    cyc(1'b0, 1'b1, 16'h0023, 32'h0, 32'hA5A5_0000 + 32'(3 * 17));
    cyc(1'b0, 1'b1, 16'h0024, 32'h0, 32'hA5A5_0000 + 32'(4 * 17));
    @(negedge clk);
    re = 1'b0;
    #2 reset = 1'b1;
    q1.delete();
    q3.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rd_valid3 !== 1'b0) begin
        errors++; $display("FAIL midflight_rd_valid[%0d]: got %b expected 0", k, rd_valid3);
      end
    end
    checks++;
    if (data_out3 !== 32'h0) begin
      errors++; $display("FAIL midflight_data_out: got %h expected 0", data_out3);
    end
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity;
    host_write(16'h0007, 32'h0000_000F);
    idle(2);
    checks++;
    if (par_err1 !== 1'b0) begin
      errors++; $display("FAIL parity_clean: got %b expected 0", par_err1);
    end
    u_dut1.mem_q[7][0] = ~u_dut1.mem_q[7][0];
    u_dut3.mem_q[7][0] = ~u_dut3.mem_q[7][0];
    cyc(1'b0, 1'b1, 16'h0007, 32'h0, 32'h0000_000E);
    idle(5);
    checks++;
    if (par_err1 !== 1'b1 || par_err3 !== 1'b1) begin
      errors++; $display("FAIL parity_flag: got %b/%b expected 1", par_err1, par_err3);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_simultaneous();
    test_out_of_range();
    test_back_to_back();
    test_latency();
    test_reset_midflight();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    idle(6);
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++; $display("FAIL pending_reads: got %0d/%0d outstanding expected 0", q1.size(), q3.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory target that answers the processor's memory master port (addr, data_in, we, re, data_out). It also accepts a lower-priority host preload write port for loading programs before or between runs. Reads return data through a parameterised register pipeline sized so the processor's two-idle-cycle fetch and load sequences sample valid data. Out-of-range accesses are flagged and never corrupt the array.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, 16..65536.
- READ_LATENCY, 1: registered read stages, legal range 1..4.
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high
- addr  input  16  processor word address
- data_in  input  32  processor write data
- we  input  1  processor write strobe, level-sensitive
- re  input  1  processor read strobe, level-sensitive
- data_out  output  32  read data, registered
- rd_valid  output  1  one-cycle pulse: data_out just updated by a read
- host_addr  input  16  preload word address
- host_wdata  input  32  preload data
- host_valid  input  1  preload request
- host_ready  output  1  preload accepted this cycle when host_valid is also high
- err_oor  output  1  sticky out-of-range flag
- par_err  output  1  sticky parity flag (only with MEM_PARITY_EN)

## Operation
- Index is addr[log2(DEPTH)-1:0]. An access is in range when addr < DEPTH, and the same rule applies to host_addr.
- Processor write:
  - Every edge with we=1 and in-range addr writes data_in to mem[index].
  - A we held high for several cycles rewrites each cycle, so the last cycle's data_in is the final value.
  - Out-of-range write: dropped, err_oor set.
- Processor read:
  - Every edge with re=1 launches a read of mem[index] into the pipeline.
  - Out-of-range read returns 32'h0 and sets err_oor.
  - re held high re-reads each cycle.
  - With re low, data_out holds its last value.
- we and re both high on the same edge: the write commits, and the read returns data_in (write-first).
- Host port:
  - host_ready = ~we & ~re & ~reset, combinational; the processor always has priority.
  - A write commits on an edge with host_valid & host_ready, with the same out-of-range rule.
  - A host write never touches data_out or rd_valid.
- err_oor and par_err clear only on reset.
- Reset clears data_out, rd_valid, err_oor, par_err and all pipeline and valid stages. Array contents are not cleared.

## Timing
- A read launched at edge k loads data_out at edge k+READ_LATENCY-1. rd_valid is high for exactly the following cycle.
- With READ_LATENCY=1, data_out updates at the same edge that samples re. Processor timing:
  - The processor raises re at edge F.
  - The responder samples it at F+1; data_out is valid before F+2, the processor's capture edge.
- Back-to-back reads produce one result per cycle, in order, with no bubbles.
- Writes take effect at the sampling edge. A read of the same address on the next edge sees the new data.
- Reset asserted mid-pipeline discards all in-flight reads. No rd_valid fires for them after reset deasserts.
- host_ready has no registered state. It falls in the same cycle that we or re rises.

## Configuration
- MEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, ^data, written with the data.
  - On each in-range read, a stored-parity mismatch sets par_err. data_out still returns the stored data bits.
  - The par_err port exists.
- MEM_PARITY_EN undefined: no parity storage, no par_err port, array is 32 bits wide.

## Test plan
- Reset, then idle: data_out=0, rd_valid=0, err_oor=0, host_ready=1.
- Fetch sequence (READ_LATENCY=1):
  - Preload via host mem[0]=32'h0205_0003.
  - Raise re with addr=0 at edge F.
  - Required: data_out=32'h0205_0003 before edge F+2, rd_valid high for the one cycle after F+1.
- STORE profile:
  - Hold we for 3 cycles at addr=16'h0010, data_in=32'h0, 32'h0, 32'hDEAD_BEEF.
  - Then read addr 16'h0010 -> 32'hDEAD_BEEF.
- Simultaneous and priority:
  - we=re=1 at addr=5, data_in=32'h1234 -> data_out=32'h1234.
  - host_valid=1 in that cycle: host_ready=0, mem[host_addr] unchanged.
- Out of range (DEPTH=1024):
  - Read addr=16'h0400 -> data_out=0, err_oor=1.
  - Write to 16'h0400 -> mem[0] unchanged.
  - err_oor stays 1 until reset.
- Latency and reset:
  - READ_LATENCY=3: reads at 3 consecutive edges -> 3 consecutive rd_valid pulses, in order, starting 2 edges after the first.
  - Reset after the second launch -> no further rd_valid.
  - With MEM_PARITY_EN: force one stored data bit flipped -> par_err=1 on the next read.
